// File: rtl/conv2d_pool_engine.sv
// conv2d_pool_engine
//   Takes one IMG_W x IMG_W frame and a K x K kernel as a single in_valid burst.
//   It computes the full-precision 2-D valid convolution. It can then apply 2x2 stride-2
//   pooling (max or average, chosen at run time). The result map is streamed row-major
//   as one contiguous out_valid burst.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; abandons any frame in progress
//   in_valid   pixel strobe; the first accepted cycle starts a frame (gaps stall loading)
//   in_ifm     pixel, row-major
//   in_weight  kernel tap, row-major, meaningful on the first K*K accepted pixels only
//   pool_sel   0: max pool, 1: average pool; captured with the first pixel of a frame
//   busy       frame in flight (load, compute or output still pending)
//   out_valid  output strobe, OUT_W*OUT_W consecutive cycles per frame
//   out_ofm    output word, forced to 0 whenever out_valid is low
module conv2d_pool_engine #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 36,
  parameter int IMG_W   = 14,
  parameter int K       = 3,
  parameter int POOL_EN = 1,
  parameter int SIGNED  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_ifm,
  input  logic [DATA_W-1:0] in_weight,
  input  logic              pool_sel,
  output logic              busy,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_ofm
);

  localparam int N_PIX   = IMG_W * IMG_W;
  localparam int KK      = K * K;
  localparam int CONV_W  = IMG_W - K + 1;
  localparam int CONV_N  = CONV_W * CONV_W;
  localparam int OUT_W   = (POOL_EN != 0) ? CONV_W / 2 : CONV_W;
  localparam int IMG_AW  = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int KK_AW   = (KK > 1) ? $clog2(KK) : 1;
  localparam int CONV_AW = (CONV_N > 1) ? $clog2(CONV_N) : 1;
  localparam int RC_B    = $clog2(IMG_W + 1);

  localparam logic [IMG_AW-1:0] PIX_LAST  = IMG_AW'(N_PIX - 1);
  localparam logic [IMG_AW:0]   KK_LIM    = (IMG_AW + 1)'(KK);
  localparam logic [RC_B-1:0]   CONV_LAST = RC_B'(CONV_W - 1);
  localparam logic [RC_B-1:0]   OUT_LAST  = RC_B'(OUT_W - 1);

  if (ACC_W < 2 * DATA_W + $clog2(KK)) begin : g_bad_acc_w
    $error("ACC_W is too narrow to hold a full-precision KxK dot product");
  end
  if (K < 1 || K > 5) begin : g_bad_k
    $error("K must be in 1..5");
  end
  if (IMG_W < K) begin : g_bad_img_w
    $error("IMG_W must be at least K");
  end
  if (OUT_W < 1) begin : g_bad_out_w
    $error("configuration produces an empty output map");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  img_mem  [N_PIX];
  logic [DATA_W-1:0]  w_mem    [KK];
  logic [ACC_W-1:0]   conv_mem [CONV_N];
  logic [IMG_AW-1:0]  pix_cnt;
  logic [RC_B-1:0]    conv_r, conv_c, out_r, out_c;
  logic [CONV_AW-1:0] conv_idx;
  logic               pool_avg;
  logic               accept, take, pix_last, conv_last, out_last;
  logic [ACC_W-1:0]   conv_sum, pool_val;

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) return ACC_W'($signed(v));
    return ACC_W'(v);
  endfunction

  function automatic logic [ACC_W+1:0] ext2(input logic [ACC_W-1:0] v);
    if (SIGNED != 0) return (ACC_W + 2)'($signed(v));
    return (ACC_W + 2)'(v);
  endfunction

  function automatic logic gt(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
    if (SIGNED != 0) return $signed(x) > $signed(y);
    return x > y;
  endfunction

  // A new frame may start only once the previous frame's last word has left the port.
  // This is why out_valid also blocks acceptance while the FSM is already back in IDLE.
  assign accept    = (state == S_IDLE) && !out_valid && in_valid;
  assign take      = accept || ((state == S_LOAD) && in_valid);
  assign pix_last  = (pix_cnt == PIX_LAST);
  assign conv_last = (conv_r == CONV_LAST) && (conv_c == CONV_LAST);
  assign out_last  = (out_r == OUT_LAST) && (out_c == OUT_LAST);
  assign busy      = (state != S_IDLE) || out_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = pix_last ? S_CALC : S_LOAD;
      S_LOAD:  if (in_valid && pix_last) state_nxt = S_CALC;
      S_CALC:  if (conv_last) state_nxt = S_OUT;
      S_OUT:   if (out_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // All K*K taps of one conv position are summed in a single cycle, so CALC takes CONV_N cycles.
  always_comb begin
    conv_sum = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        conv_sum = conv_sum
                 + ext(img_mem[IMG_AW'((int'(conv_r) + i) * IMG_W + int'(conv_c) + j)])
                 * ext(w_mem[KK_AW'(i * K + j)]);
      end
    end
  end

  if (POOL_EN != 0) begin : g_pool
    logic [CONV_AW-1:0] base;
    logic [ACC_W-1:0]   pa, pb, pc, pd, m_top, m_bot, v_max;
    logic [ACC_W+1:0]   sum4;

    // Bits [ACC_W+1:2] of the extended 4-term sum are the floor of sum/4 in both signed and unsigned modes.
    always_comb begin
      base     = CONV_AW'(2 * int'(out_r) * CONV_W + 2 * int'(out_c));
      pa       = conv_mem[base];
      pb       = conv_mem[CONV_AW'(int'(base) + 1)];
      pc       = conv_mem[CONV_AW'(int'(base) + CONV_W)];
      pd       = conv_mem[CONV_AW'(int'(base) + CONV_W + 1)];
      m_top    = gt(pb, pa) ? pb : pa;
      m_bot    = gt(pd, pc) ? pd : pc;
      v_max    = gt(m_bot, m_top) ? m_bot : m_top;
      sum4     = ext2(pa) + ext2(pb) + ext2(pc) + ext2(pd);
      pool_val = pool_avg ? sum4[ACC_W+1:2] : v_max;
    end
  end else begin : g_nopool
    logic unused_pool_avg;
    assign unused_pool_avg = pool_avg;

    always_comb pool_val = conv_mem[CONV_AW'(int'(out_r) * CONV_W + int'(out_c))];
  end

  // Frame counters and the registered output port.
  // All counters are reset because CALC and OUT rely on starting from position 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= '0;
      conv_r    <= '0;
      conv_c    <= '0;
      conv_idx  <= '0;
      out_r     <= '0;
      out_c     <= '0;
      pool_avg  <= 1'b0;
      out_valid <= 1'b0;
      out_ofm   <= '0;
    end else begin
      out_valid <= (state == S_OUT);
      out_ofm   <= (state == S_OUT) ? pool_val : '0;
      if (accept) pool_avg <= pool_sel;
      if (take) pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
      if (state == S_CALC) begin
        conv_idx <= conv_last ? '0 : conv_idx + 1'b1;
        if (conv_c == CONV_LAST) begin
          conv_c <= '0;
          conv_r <= (conv_r == CONV_LAST) ? '0 : conv_r + 1'b1;
        end else begin
          conv_c <= conv_c + 1'b1;
        end
      end
      if (state == S_OUT) begin
        if (out_c == OUT_LAST) begin
          out_c <= '0;
          out_r <= (out_r == OUT_LAST) ? '0 : out_r + 1'b1;
        end else begin
          out_c <= out_c + 1'b1;
        end
      end
    end
  end

  // Frame, kernel and conv-map storage; contents are don't-care until rewritten by the next frame.
  always_ff @(posedge clk) begin
    if (take) begin
      img_mem[pix_cnt] <= in_ifm;
      if ({1'b0, pix_cnt} < KK_LIM) w_mem[pix_cnt[KK_AW-1:0]] <= in_weight;
    end
    if (state == S_CALC) conv_mem[conv_idx] <= conv_sum;
  end

endmodule
